// File: rtl/recon_pixel_serializer.sv
// Buffers reconstructed 2x8 blocks of three 14-bit components in a small FIFO
// and streams them out one clipped 13-bit pixel at a time under valid/ready.
module recon_pixel_serializer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [12:0]  maxPoint,
  input  logic         pReconBlk_valid,
  input  logic [671:0] pReconBlk_p,
  output logic         blk_ready,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [38:0]  pix_data,
  output logic         pix_row,
  output logic [2:0]   pix_col,
  output logic         pix_last,
  output logic         overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [671:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, xfer;
  logic [671:0]     headBlk;
  logic [13:0]      sample;

  // Space is judged on the registered count only, so a same-cycle pop never frees room.
  assign blk_ready = (count_q < DEPTH_C);
  assign pix_valid = (count_q != '0);
  assign overflow  = overflow_q;
  assign xfer      = pix_valid & pix_ready;
  assign pop       = xfer & (idx_q == 4'd15);
  assign push      = pReconBlk_valid & blk_ready & ~flush;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (xfer) idx_d = idx_q + 4'd1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (pReconBlk_valid & ~blk_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Block storage is never observable while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= pReconBlk_p;
  end

  always_comb begin
    headBlk  = mem_q[rdPtr_q];
    sample   = '0;
    pix_data = '0;
    pix_row  = 1'b0;
    pix_col  = 3'd0;
    pix_last = 1'b0;
    if (pix_valid) begin
      for (int k = 0; k < 3; k++) begin
        sample = headBlk[(k * 16 + int'(idx_q)) * 14 +: 14];
        if (sample[13])
          pix_data[k*13 +: 13] = '0;
        else if (sample[12:0] > maxPoint)
          pix_data[k*13 +: 13] = maxPoint;
        else
          pix_data[k*13 +: 13] = sample[12:0];
      end
      pix_row  = idx_q[3];
      pix_col  = idx_q[2:0];
      pix_last = (idx_q == 4'd15);
    end
  end

endmodule

// File: tb/tb_recon_pixel_serializer.sv
// Self-checking bench: directed scenarios plus a random phase, compared each
// cycle against a queue-of-blocks reference model.
module tb_recon_pixel_serializer;

  localparam int DEPTH = 2;
  typedef logic [671:0] blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [12:0]  maxPoint;
  logic         pReconBlk_valid;
  logic [671:0] pReconBlk_p;
  logic         blk_ready;
  logic         pix_valid;
  logic         pix_ready;
  logic [38:0]  pix_data;
  logic         pix_row;
  logic [2:0]   pix_col;
  logic         pix_last;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  blk_t model[$];
  int   mIdx = 0;
  bit   mOvf = 1'b0;

  recon_pixel_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .maxPoint(maxPoint),
    .pReconBlk_valid(pReconBlk_valid),
    .pReconBlk_p(pReconBlk_p),
    .blk_ready(blk_ready),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_row(pix_row),
    .pix_col(pix_col),
    .pix_last(pix_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic blk_t mkBlk(input int s0, input int s1, input int s2);
    blk_t b;
    logic [13:0] v;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      v = 14'(s0); b[(0 * 16 + i) * 14 +: 14] = v;
      v = 14'(s1); b[(1 * 16 + i) * 14 +: 14] = v;
      v = 14'(s2); b[(2 * 16 + i) * 14 +: 14] = v;
    end
    return b;
  endfunction

  function automatic blk_t randBlk();
    blk_t b;
    for (int i = 0; i < 21; i++) b[i * 32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [12:0] clipRef(input blk_t b, input int comp, input int pixIdx);
    logic signed [13:0] sv;
    int s;
    sv = b[(comp * 16 + pixIdx) * 14 +: 14];
    s  = sv;
    if (s < 0) return 13'd0;
    if (s > int'(maxPoint)) return maxPoint;
    return 13'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expVal);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [38:0] ed;
    bit ev;
    ed = '0;
    ev = (model.size() != 0);
    if (ev)
      for (int k = 0; k < 3; k++) ed[k * 13 +: 13] = clipRef(model[0], k, mIdx);
    checkOutput({tag, "_valid"}, 64'(pix_valid), 64'(ev));
    checkOutput({tag, "_ready"}, 64'(blk_ready), 64'(model.size() < DEPTH));
    checkOutput({tag, "_ovf"}, 64'(overflow), 64'(mOvf));
    checkOutput({tag, "_data"}, 64'(pix_data), 64'(ed));
    checkOutput({tag, "_row"}, 64'(pix_row), ev ? 64'(mIdx / 8) : 64'd0);
    checkOutput({tag, "_col"}, 64'(pix_col), ev ? 64'(mIdx % 8) : 64'd0);
    checkOutput({tag, "_last"}, 64'(pix_last), 64'(ev && mIdx == 15));
  endtask

  // One clock cycle: drive, check current outputs, then advance the model.
  task automatic applyStimulus(input bit v, input blk_t b, input bit r, input bit f, input string tag);
    bit canPush;
    bit doPop;
    pReconBlk_valid = v;
    pReconBlk_p     = b;
    pix_ready       = r;
    flush           = f;
    #1;
    checkAll(tag);
    @(posedge clk);
    if (f) begin
      model.delete();
      mIdx = 0;
      mOvf = 1'b0;
    end else begin
      canPush = (model.size() < DEPTH);
      doPop   = 1'b0;
      if (model.size() != 0 && r) begin
        if (mIdx == 15) begin
          doPop = 1'b1;
          mIdx  = 0;
        end else begin
          mIdx++;
        end
      end
      if (doPop) void'(model.pop_front());
      if (v) begin
        if (canPush) model.push_back(b);
        else mOvf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit r, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, randBlk(), r, 1'b0, tag);
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    maxPoint        = 13'd1023;
    pReconBlk_valid = 1'b0;
    pReconBlk_p     = '0;
    pix_ready       = 1'b0;

    #22;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b1, mkBlk(100, 100, 100), 1'b1, 1'b0, "single_push");
    idle(17, 1'b1, "single");

    applyStimulus(1'b1, mkBlk(-5, 2000, 512), 1'b1, 1'b0, "clip_push");
    checkOutput("clip_value", 64'(pix_data), {25'd0, 13'd512, 13'd1023, 13'd0});
    idle(16, 1'b1, "clip");

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randBlk(), 1'b0, 1'b0, "bp_push");
    checkOutput("bp_overflow", 64'(overflow), 64'd1);
    idle(3, 1'b0, "bp_hold");
    idle(33, 1'b1, "bp_drain");

    applyStimulus(1'b0, '0, 1'b0, 1'b1, "flush1");
    applyStimulus(1'b1, randBlk(), 1'b0, 1'b0, "pp_fill");
    applyStimulus(1'b1, randBlk(), 1'b0, 1'b0, "pp_fill");
    idle(15, 1'b1, "pp_stream");
    applyStimulus(1'b1, randBlk(), 1'b1, 1'b0, "pp_idx15");
    checkOutput("pp_dropped", 64'(overflow), 64'd1);
    applyStimulus(1'b1, randBlk(), 1'b1, 1'b0, "pp_accept");
    idle(33, 1'b1, "pp_drain");

    applyStimulus(1'b0, '0, 1'b0, 1'b1, "flush2");
    applyStimulus(1'b1, randBlk(), 1'b0, 1'b0, "fl_fill");
    applyStimulus(1'b1, randBlk(), 1'b0, 1'b0, "fl_fill");
    idle(7, 1'b1, "fl_stream");
    applyStimulus(1'b1, randBlk(), 1'b1, 1'b1, "fl_at7");
    checkOutput("fl_empty", 64'(pix_valid), 64'd0);
    applyStimulus(1'b1, randBlk(), 1'b1, 1'b0, "fl_push");
    checkOutput("fl_restart_col", 64'(pix_col), 64'd0);
    idle(17, 1'b1, "fl_after");

    applyStimulus(1'b1, randBlk(), 1'b1, 1'b0, "rs_push");
    idle(5, 1'b1, "rs_stream");
    pReconBlk_valid = 1'b0;
    rst = 1'b1;
    model.delete();
    mIdx = 0;
    mOvf = 1'b0;
    #1;
    checkAll("rs_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, randBlk(), 1'b1, 1'b0, "rs_push2");
    idle(17, 1'b1, "rs_after");

    maxPoint = 13'($urandom_range(0, 8191));
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), randBlk(), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 60) == 0), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recon_pixel_serializer.md
RECON_PIXEL_SERIALIZER -- requirements
Module: recon_pixel_serializer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of reconstructed blocks buffered (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 flush  input  1  synchronous clear of all state.
REQ-005 maxPoint  input  13  upper clip bound; held quasi-static per slice.
REQ-006 pReconBlk_valid  input  1  one-cycle strobe: pReconBlk_p holds a complete 2x8 block.
REQ-007 pReconBlk_p  input  672  signed 14-bit samples; sample (comp,r,c) at bits [(comp*16+r*8+c)*14 +:14], comp 0..2, r 0..1, c 0..7.
REQ-008 blk_ready  output  1  high when the block FIFO can accept a block (count < FIFO_DEPTH).
REQ-009 pix_valid  output  1  pix_data/pix_row/pix_col/pix_last are valid.
REQ-010 pix_ready  input  1  downstream accepts the current pixel.
REQ-011 pix_data  output  39  clipped pixel; comp k at bits [k*13 +:13].
REQ-012 pix_row  output  1  row of current pixel within the block.
REQ-013 pix_col  output  3  column of current pixel within the block.
REQ-014 pix_last  output  1  current pixel is r=1, c=7 (last of block).
REQ-015 overflow  output  1  sticky; set when a block strobe arrives while blk_ready=0.

Function
REQ-016 FIFO SHALL store whole blocks (672 bits each); write pointer, read pointer, and count are registers; count width is clog2(FIFO_DEPTH)+1.
REQ-017 Push occurs when pReconBlk_valid=1 and blk_ready=1; the block is written at that rising edge.
REQ-018 blk_ready SHALL be a function of registered count only; a pop in the same cycle does not free space for a same-cycle push.
REQ-019 Push when blk_ready=0: block discarded, FIFO unchanged, overflow set to 1 and held until rst/flush.
REQ-020 pix_valid = (count != 0); first pixel of a block pushed into an empty FIFO at edge N is valid in the cycle after edge N (latency 1).
REQ-021 A 4-bit pixel index (0..15) selects from the head block; index i maps to r=i[3], c=i[2:0]; order is row 0 c0..c7, then row 1 c0..c7.
REQ-022 A transfer occurs when pix_valid & pix_ready; the index increments on each transfer; on transfer at index 15 the index wraps to 0 and the head block pops (read pointer +1, count -1).
REQ-023 When pix_valid=0, pix_ready is ignored and the index holds.
REQ-024 Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-025 Pointers wrap modulo FIFO_DEPTH.
REQ-026 While pix_valid=1 and pix_ready=0, all pix_* outputs SHALL remain stable.
REQ-027 Clip per component: sample < 0 -> 0; sample > maxPoint -> maxPoint; else sample[12:0].
REQ-028 pix_data, pix_row, pix_col, pix_last are combinational from head block, index, maxPoint; they read 0 when pix_valid=0.
REQ-029 flush=1 at an edge: count, pointers, index, overflow cleared to 0; a push in the same cycle is discarded without setting overflow.

Reset
REQ-030 rst=1 asynchronously clears count, pointers, index, overflow; while rst=1: blk_ready=1, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, overflow=0.
REQ-031 Reset mid-block: partially streamed block is abandoned; after release, the FIFO is empty and the index is 0.
REQ-032 Block storage needs no reset; contents are never visible while count=0.

Verification
REQ-033 Single block: all samples = 100, maxPoint=1023, pix_ready=1 -> 16 consecutive pixels, data 100 per component, cols 0..7 row 0 then row 1, pix_last only on 16th; blk_ready stays 1.
REQ-034 Clip: comp0 samples -5, comp1 2000, comp2 512, maxPoint=1023 -> pix_data comp0=0, comp1=1023, comp2=512 for every pixel.
REQ-035 Backpressure: push 3 blocks with pix_ready=0 -> blk_ready=0 after 2 pushes, third push sets overflow=1; outputs stable; on release exactly 32 pixels from blocks 1,2 in order.
REQ-036 Push with pop: FIFO full, pix_ready=1, push on cycle of index-15 transfer -> push dropped, overflow=1; next cycle push accepted.
REQ-037 Flush at index 7 of block 1 with block 2 queued -> next cycle pix_valid=0, blk_ready=1, overflow=0; next pushed block streams from index 0.
REQ-038 rst pulse at index 5 -> outputs zero immediately (asynchronous), blk_ready=1; next block streams from index 0.
